prach_reshape_lanes: RTL and testbench
======================================

Name: prach_reshape_lanes

Overview:
- Generalised lane/time corner-turn for the PRACH channel path. Replaces the fixed 2-lane swap with an LANES×LANES block transpose.
- Accepts LANES parallel sample lanes. Every LANES valid beats form one block, which is emitted transposed: output beat r, lane k = input beat k, lane r.
- Ping-pong buffered, so input gaps are tolerated and output blocks are contiguous.
- Adds a runtime bypass (no transpose, same latency), channel-tag masking, and partial-block drop reporting.

Parameters:
- LANES, 2, lane count; power of two, 2..8.
- DATA_W, 16, bits per lane sample.
- CHN_W, 8, channel tag width.
- NUM_CHN, 48, tags >= NUM_CHN are emitted with dout_dv=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_bypass  in  1  1 = pass blocks untransposed; sampled at block start
- din_data  in  LANES*DATA_W  lane l at bits [l*DATA_W +: DATA_W]
- din_dv  in  1  beat valid
- din_chn  in  CHN_W  channel tag of beat
- sync_in  in  1  block/frame start; qualified by din_dv
- dout_data  out  LANES*DATA_W  transposed (or bypassed) lanes
- dout_dv  out  1  output beat valid, after NUM_CHN mask
- dout_chn  out  CHN_W  tag of output beat
- sync_out  out  1  marks output beat 0 of a block whose input beat 0 had sync_in
- partial_drop  out  1  one-cycle pulse when an incomplete block is discarded

Behaviour:
- Reset (rst=1 at clk edge):
  - dout_data=0, dout_dv=0, dout_chn=0, sync_out=0, partial_drop=0.
  - Write index w_idx=0, write bank=0, reader idle, r_idx=0.
  - Reset mid-block or mid-read discards all buffered data; no further output until a new full block completes.
- Write side (only beats with din_dv=1 count):
  - Store lanes in buf[wbank][w_idx][*], tag[wbank][w_idx]=din_chn, sync flag at w_idx=0.
  - At w_idx==0, latch cfg_bypass into that bank's mode bit.
  - Beat accepted at w_idx==LANES-1: w_idx->0, wbank toggles, reader starts on the filled bank next cycle.
  - din_dv=0 cycles hold state; gaps are allowed anywhere in a block.
- sync_in with din_dv=1:
  - w_idx==0: beat becomes beat 0 with sync flag.
  - w_idx!=0: partial beats discarded, partial_drop pulses next cycle, and the current beat is written as beat 0 of the same bank.
  - sync_in with din_dv=0 is ignored.
- Read side FSM (IDLE, READ):
  - IDLE->READ when a bank completes.
  - READ outputs one registered beat per cycle for r_idx=0..LANES-1, then returns to IDLE. Goes straight back to READ if another bank completed on the last read cycle.
- Output beat r:
  - Transpose mode: dout_data lane k = buf[b][k][r].
  - Bypass mode: lane k = buf[b][r][k].
  - dout_chn = tag[b][r]; dout_dv = (tag[b][r] < NUM_CHN).
  - sync_out = sync flag & (r==0).
- Latency: last input beat of a block accepted at cycle T -> output beat 0 registered at T+1, beat r at T+1+r.
- No overlap: a block needs >= LANES cycles to fill and reads take exactly LANES cycles, so reads never collide. A write into the idle bank during a read is legal.
- Tags are not arithmetically modified; the comparison against NUM_CHN is unsigned.
- cfg_bypass changes mid-block take effect at the next block start only.

Decomposition:
- Package prach_reshape_pkg:
  - lane_idx_t = logic [$clog2(LANES)-1:0]
  - rd_state_e {IDLE, READ}
  - constant MAX_LANES=8
  - helper function lane slice extraction.
- Sub-module prach_reshape_bank: one LANES×LANES×DATA_W register array plus tag/sync/mode storage. Has a row write port and a row-or-column read mux. Instantiated twice (ping-pong).

Test Plan:
- LANES=2, bypass=0: beats {lane0,lane1}={A0,A1},{B0,B1}, tags 4,5, sync on the first beat -> at T+1 out {A0,B0} chn 4 sync_out=1; at T+2 out {A1,B1} chn 5.
- LANES=4, din_dv toggling 1-0-1-0 over 4 valid beats of values 0x00rc (r=beat, c=lane) -> output beat r lane k = 0x00kr; four contiguous dout_dv cycles starting 1 cycle after the 4th valid beat.
- LANES=2, tags 47,48 -> both beats emitted with data; dout_dv=1 for 47 and 0 for 48.
- LANES=4, sync_in at 3rd beat of a block -> partial_drop pulses once; the sync beat becomes beat 0; the next output block contains only post-sync data.
- cfg_bypass set mid-block -> that block is transposed; the next block's output equals its input order beat for beat.
- Continuous din_dv=1 for 16 blocks (LANES=4) -> dout_dv continuously high with no gaps. Assert rst during a read -> outputs 0 next cycle, and no residual beats after rst releases.

Source files
------------

// File: rtl/prach_reshape_pkg.sv
// -----------------------------------------------------------------------------
// prach_reshape_pkg
//
// Shared types and helpers for the PRACH lane/time corner-turn
// (prach_reshape_lanes and its ping-pong bank, prach_reshape_bank).
//
// Contents:
//   MAX_LANES   - largest supported lane count
//   lane_idx_t  - index wide enough for any supported lane count
//   rd_state_e  - read-side FSM states
//   lane_lsb()  - LSB position of one lane inside a packed multi-lane word
// -----------------------------------------------------------------------------
package prach_reshape_pkg;

    localparam int MAX_LANES = 8;

    typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    // Lane l of a packed word occupies bits [l*data_w +: data_w].
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/prach_reshape_bank.sv
// -----------------------------------------------------------------------------
// prach_reshape_bank
//
// One half of the ping-pong buffer: a LANES x LANES array of DATA_W samples
// plus, per stored beat, its channel tag. Beat 0 of the block additionally
// stores the block's sync flag and its bypass mode.
//
// The write port stores one full input beat (a "row") at wr_idx. The read
// port returns output beat rd_idx, which is either a column (transpose) or a
// row (bypass) of the array, chosen by the mode latched with beat 0.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write the beat presented on wr_row/wr_chn at wr_idx
//   wr_idx   in   beat index inside the block (row)
//   wr_row   in   LANES*DATA_W input beat, lane l at [l*DATA_W +: DATA_W]
//   wr_chn   in   channel tag of the beat
//   wr_sync  in   sync flag, stored only when wr_idx == 0
//   wr_mode  in   bypass mode, stored only when wr_idx == 0
//   rd_idx   in   output beat index
//   rd_data  out  output beat (column rd_idx, or row rd_idx in bypass)
//   rd_chn   out  tag of stored beat rd_idx
//   rd_sync  out  sync flag of the stored block
// -----------------------------------------------------------------------------
module prach_reshape_bank
    import prach_reshape_pkg::*;
#(
    parameter  int LANES  = 2,
    parameter  int DATA_W = 16,
    parameter  int CHN_W  = 8,
    localparam int IDX_W  = $clog2(LANES),
    localparam int ROW_W  = LANES * DATA_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [CHN_W-1:0] wr_chn,
    input  logic             wr_sync,
    input  logic             wr_mode,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ROW_W-1:0] rd_data,
    output logic [CHN_W-1:0] rd_chn,
    output logic             rd_sync
);

    // Sample (row r, lane l) lives at bits [(r*LANES + l)*DATA_W +: DATA_W].
    logic [LANES*ROW_W-1:0] cells;
    logic [LANES*CHN_W-1:0] tags;
    logic                   sync_flag;
    logic                   mode;

    // NOTE: the sample array and its tags are not reset. Reset only clears the
    // write/read control in the top level, which is enough to make stale
    // contents unreachable, and keeps the array free of a reset fan-out.
    // NOTE: clocked state is always assigned with <= so every block sees the
    // pre-edge value of every register regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            cells[int'(wr_idx)*ROW_W +: ROW_W] <= wr_row;
            tags[int'(wr_idx)*CHN_W +: CHN_W]  <= wr_chn;
            if (wr_idx == '0) begin
                sync_flag <= wr_sync;
                mode      <= wr_mode;
            end
        end
    end

    // Output lane k of beat r: transpose takes input beat k, lane r;
    // bypass takes input beat r, lane k.
    for (genvar k = 0; k < LANES; k++) begin : g_rd_lane
        logic [DATA_W-1:0] col_sample;
        logic [DATA_W-1:0] row_sample;

        assign col_sample = cells[(k*LANES + int'(rd_idx))*DATA_W +: DATA_W];
        assign row_sample = cells[(int'(rd_idx)*LANES + k)*DATA_W +: DATA_W];

        assign rd_data[lane_lsb(k, DATA_W) +: DATA_W] = mode ? row_sample
                                                             : col_sample;
    end

    assign rd_chn  = tags[int'(rd_idx)*CHN_W +: CHN_W];
    assign rd_sync = sync_flag;

endmodule

// File: rtl/prach_reshape_lanes.sv
// -----------------------------------------------------------------------------
// prach_reshape_lanes
//
// LANES x LANES lane/time corner-turn for the PRACH channel path. Every LANES
// valid input beats form one block; the block is emitted transposed
// (output beat r, lane k = input beat k, lane r) or, when bypass was selected
// at the block's first beat, in input order. Two banks are used ping-pong so
// input gaps are tolerated and each output block is LANES contiguous beats.
//
// A sync_in on a valid beat in the middle of a block discards the beats
// gathered so far (pulsing partial_drop) and restarts the block with that
// beat. Output beats whose tag is >= NUM_CHN still carry data and tag but
// have dout_dv low.
//
// Latency: last input beat of a block accepted on edge T -> output beat r is
// registered on edge T+1+r.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   cfg_bypass    in   1 = emit blocks untransposed; sampled at block start
//   din_data      in   LANES*DATA_W input beat, lane l at [l*DATA_W +: DATA_W]
//   din_dv        in   input beat valid
//   din_chn       in   channel tag of the input beat
//   sync_in       in   block start, only meaningful with din_dv
//   dout_data     out  transposed (or bypassed) output beat
//   dout_dv       out  output beat valid after the NUM_CHN mask
//   dout_chn      out  tag of the output beat
//   sync_out      out  beat 0 of a block whose input beat 0 carried sync_in
//   partial_drop  out  one-cycle pulse when an incomplete block is discarded
// -----------------------------------------------------------------------------
module prach_reshape_lanes
    import prach_reshape_pkg::*;
#(
    parameter int          LANES   = 2,
    parameter int          DATA_W  = 16,
    parameter int          CHN_W   = 8,
    parameter int unsigned NUM_CHN = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_bypass,
    input  logic [LANES*DATA_W-1:0] din_data,
    input  logic                    din_dv,
    input  logic [CHN_W-1:0]        din_chn,
    input  logic                    sync_in,
    output logic [LANES*DATA_W-1:0] dout_data,
    output logic                    dout_dv,
    output logic [CHN_W-1:0]        dout_chn,
    output logic                    sync_out,
    output logic                    partial_drop
);

    localparam int               IDX_W    = $clog2(LANES);
    localparam int               ROW_W    = LANES * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    // -------------------------------------------------------------------------
    // Write side
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] w_idx;
    logic             wbank;
    logic [IDX_W-1:0] wr_idx_eff;
    logic             restart;
    logic             block_done;

    // A sync beat always lands at index 0; if the block had already started,
    // the earlier beats are abandoned and the same bank is reused.
    assign wr_idx_eff = sync_in ? '0 : w_idx;
    assign restart    = din_dv && sync_in && (w_idx != '0);
    assign block_done = din_dv && (wr_idx_eff == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_idx        <= '0;
            wbank        <= 1'b0;
            partial_drop <= 1'b0;
        end else begin
            partial_drop <= restart;
            if (din_dv) begin
                if (block_done) begin
                    w_idx <= '0;
                    wbank <= ~wbank;
                end else begin
                    w_idx <= wr_idx_eff + IDX_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Ping-pong banks
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] r_idx;
    logic [ROW_W-1:0] bank_data [2];
    logic [CHN_W-1:0] bank_chn  [2];
    logic             bank_sync [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        prach_reshape_bank #(
            .LANES  (LANES),
            .DATA_W (DATA_W),
            .CHN_W  (CHN_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (din_dv && (wbank == 1'(b))),
            .wr_idx  (wr_idx_eff),
            .wr_row  (din_data),
            .wr_chn  (din_chn),
            .wr_sync (sync_in),
            .wr_mode (cfg_bypass),
            .rd_idx  (r_idx),
            .rd_data (bank_data[b]),
            .rd_chn  (bank_chn[b]),
            .rd_sync (bank_sync[b])
        );
    end

    // -------------------------------------------------------------------------
    // Read side
    // -------------------------------------------------------------------------
    rd_state_e        state;
    logic             rbank;
    logic [ROW_W-1:0] sel_data;
    logic [CHN_W-1:0] sel_chn;
    logic             sel_sync;

    assign sel_data = rbank ? bank_data[1] : bank_data[0];
    assign sel_chn  = rbank ? bank_chn[1]  : bank_chn[0];
    assign sel_sync = rbank ? bank_sync[1] : bank_sync[0];

    // A block needs at least LANES write edges and a read takes exactly LANES
    // edges, so a new completion can only coincide with the last read beat;
    // that case chains directly into the next read with no idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r_idx     <= '0;
            rbank     <= 1'b0;
            dout_data <= '0;
            dout_dv   <= 1'b0;
            dout_chn  <= '0;
            sync_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout_data <= '0;
                    dout_dv   <= 1'b0;
                    dout_chn  <= '0;
                    sync_out  <= 1'b0;
                    if (block_done) begin
                        state <= READ;
                        rbank <= wbank;
                        r_idx <= '0;
                    end
                end
                READ: begin
                    dout_data <= sel_data;
                    dout_chn  <= sel_chn;
                    // Unsigned compare; masked tags still carry their data.
                    dout_dv   <= (32'(sel_chn) < NUM_CHN);
                    sync_out  <= sel_sync && (r_idx == '0);
                    if (r_idx == LAST_IDX) begin
                        r_idx <= '0;
                        if (block_done) begin
                            rbank <= wbank;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prach_reshape_lanes.sv
// -----------------------------------------------------------------------------
// tb_prach_reshape_lanes
//
// Self-checking bench for prach_reshape_lanes with LANES=4. A block-level
// reference model collects accepted beats into a queue, and on completion
// computes the expected output block from the transpose/bypass rules, with
// each beat stamped with the clock edge on which it must appear. Every edge
// the DUT outputs are compared against that schedule.
// -----------------------------------------------------------------------------
module tb_prach_reshape_lanes;

    localparam int LANES   = 4;
    localparam int DATA_W  = 16;
    localparam int CHN_W   = 8;
    localparam int NUM_CHN = 48;
    localparam int BW      = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_bypass;
    logic [BW-1:0]     din_data;
    logic              din_dv;
    logic [CHN_W-1:0]  din_chn;
    logic              sync_in;
    logic [BW-1:0]     dout_data;
    logic              dout_dv;
    logic [CHN_W-1:0]  dout_chn;
    logic              sync_out;
    logic              partial_drop;

    always #5 clk = ~clk;

    prach_reshape_lanes #(
        .LANES   (LANES),
        .DATA_W  (DATA_W),
        .CHN_W   (CHN_W),
        .NUM_CHN (NUM_CHN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_bypass   (cfg_bypass),
        .din_data     (din_data),
        .din_dv       (din_dv),
        .din_chn      (din_chn),
        .sync_in      (sync_in),
        .dout_data    (dout_data),
        .dout_dv      (dout_dv),
        .dout_chn     (dout_chn),
        .sync_out     (sync_out),
        .partial_drop (partial_drop)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        int               edge_no;
        logic [BW-1:0]    data;
        logic [CHN_W-1:0] chn;
        logic             sync;
    } exp_t;

    exp_t             exp_q[$];
    logic [BW-1:0]    blk_data[$];
    logic [CHN_W-1:0] blk_chn[$];
    logic             blk_sync;
    logic             blk_mode;
    int               drop_edge = -1;
    bit               was_rst;
    int               dv_run;

    task automatic model(input logic r, input logic dv, input logic sy,
                         input logic byp, input logic [BW-1:0] d,
                         input logic [CHN_W-1:0] c);
        exp_t          e;
        logic [BW-1:0] src;
        if (r) begin
            exp_q.delete();
            blk_data.delete();
            blk_chn.delete();
            drop_edge = -1;
            was_rst   = 1'b1;
            return;
        end
        was_rst = 1'b0;
        if (!dv) return;
        if (sy && blk_data.size() != 0) begin
            blk_data.delete();
            blk_chn.delete();
            drop_edge = cyc;
        end
        if (blk_data.size() == 0) begin
            blk_sync = sy;
            blk_mode = byp;
        end
        blk_data.push_back(d);
        blk_chn.push_back(c);
        if (blk_data.size() == LANES) begin
            for (int rr = 0; rr < LANES; rr++) begin
                e.edge_no = cyc + 1 + rr;
                e.chn     = blk_chn[rr];
                e.sync    = blk_sync && (rr == 0);
                e.data    = '0;
                for (int k = 0; k < LANES; k++) begin
                    if (blk_mode) begin
                        src = blk_data[rr];
                        e.data[k*DATA_W +: DATA_W] = src[k*DATA_W +: DATA_W];
                    end else begin
                        src = blk_data[k];
                        e.data[k*DATA_W +: DATA_W] = src[rr*DATA_W +: DATA_W];
                    end
                end
                exp_q.push_back(e);
            end
            blk_data.delete();
            blk_chn.delete();
        end
    endtask

    task automatic compare();
        exp_t e;
        if (was_rst) begin
            check("rst_data", dout_data, '0);
            check("rst_dv", dout_dv, 1'b0);
            check("rst_chn", dout_chn, '0);
            check("rst_sync", sync_out, 1'b0);
            check("rst_drop", partial_drop, 1'b0);
            return;
        end
        check("partial_drop", partial_drop, drop_edge == cyc);
        if (exp_q.size() != 0 && exp_q[0].edge_no == cyc) begin
            e = exp_q.pop_front();
            check("data", dout_data, e.data);
            check("chn", dout_chn, e.chn);
            check("dv", dout_dv, e.chn < NUM_CHN);
            check("sync_out", sync_out, e.sync);
        end else begin
            check("idle_dv", dout_dv, 1'b0);
            check("idle_sync", sync_out, 1'b0);
        end
        if (exp_q.size() != 0 && exp_q[0].edge_no < cyc)
            check("missed_beat", 64'(exp_q[0].edge_no), 64'(cyc));
    endtask

    // Drive one cycle of inputs, advance one edge, update model, check.
    task automatic step(input logic r, input logic dv, input logic sy,
                        input logic byp, input logic [BW-1:0] d,
                        input logic [CHN_W-1:0] c);
        rst = r; din_dv = dv; sync_in = sy; cfg_bypass = byp;
        din_data = d; din_chn = c;
        @(posedge clk);
        cyc++;
        model(r, dv, sy, byp, d, c);
        #1;
        dv_run = dout_dv ? dv_run + 1 : 0;
        compare();
    endtask

    function automatic logic [BW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'(i & 1), 1'b0, rnd_data(), CHN_W'($urandom));
    endtask

    // Beat b, lane c carries 0x00bc.
    function automatic logic [BW-1:0] pat(input int b);
        logic [BW-1:0] v;
        for (int c = 0; c < LANES; c++) v[c*DATA_W +: DATA_W] = DATA_W'(b*16 + c);
        return v;
    endfunction

    int max_run;

    initial begin
        rst = 1'b1; din_dv = 1'b0; sync_in = 1'b0; cfg_bypass = 1'b0;
        din_data = '0; din_chn = '0;
        max_run = 0; dv_run = 0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, rnd_data(), 8'd3);
        idle(3);

        // Contiguous block, tags 4..7, sync on beat 0, transpose
        for (int b = 0; b < LANES; b++)
            step(1'b0, 1'b1, b == 0, 1'b0, rnd_data(), CHN_W'(4 + b));
        idle(6);

        // Gapped 1-0-1-0 beats with 0x00rc pattern
        for (int b = 0; b < LANES; b++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, pat(b), 8'd10);
            if (b != LANES - 1) step(1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), 8'd99);
        end
        idle(6);

        // NUM_CHN boundary: tags 46,47,48,49
        for (int b = 0; b < LANES; b++)
            step(1'b0, 1'b1, 1'b0, 1'b0, rnd_data(), CHN_W'(46 + b));
        idle(6);

        // sync on 3rd beat: drop, restart, only post-sync data emitted
        for (int b = 0; b < 2 + LANES; b++)
            step(1'b0, 1'b1, b == 2, 1'b0, rnd_data(), CHN_W'(20 + b));
        idle(6);

        // Bypass raised mid-block: this block transposed, next bypassed
        for (int b = 0; b < LANES; b++)
            step(1'b0, 1'b1, 1'b0, b >= 2, pat(b), CHN_W'(30 + b));
        for (int b = 0; b < LANES; b++)
            step(1'b0, 1'b1, 1'b0, 1'b1, pat(b + 4), CHN_W'(34 + b));
        idle(6);

        // 16 back-to-back blocks, all tags unmasked: dout_dv must stay high
        max_run = 0;
        for (int b = 0; b < 16 * LANES; b++) begin
            step(1'b0, 1'b1, (b % LANES) == 0, 1'($urandom_range(0, 1)),
                 rnd_data(), CHN_W'($urandom_range(0, NUM_CHN - 1)));
            if (dv_run > max_run) max_run = dv_run;
        end
        for (int i = 0; i < LANES; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), '0);
            if (dv_run > max_run) max_run = dv_run;
        end
        check("contiguous_dv_run", 64'(max_run), 64'(16 * LANES));

        // Reset in the middle of a read, plus a half-filled block
        for (int b = 0; b < LANES + 2; b++)
            step(1'b0, 1'b1, 1'b0, 1'b0, rnd_data(), CHN_W'(b));
        step(1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_data(), '0);
        idle(8);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 rnd_data(),
                 CHN_W'($urandom_range(0, 63)));
        end
        idle(2 * LANES);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
